perf_event_counters: RTL and testbench
======================================

# perf_event_counters

Two free-running 64-bit hardware event counters for one core, each counting a software-selected event from the core's performance event vector. The block sits directly upstream of the control register file. It takes the two event-select values that software programs through control registers and returns the two live counts, which software reads back as low/high 32-bit halves. The pipeline stages drive the event pulses.

## Interface
Parameters:
- NUM_EVENTS, 8, number of event inputs; any value ≥ 1 (need not be a power of two).
- EVENT_IDX_WIDTH, $clog2(NUM_EVENTS) (minimum 1), width of each select input.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- perf_events  input  NUM_EVENTS  one-cycle event pulses; bit i high means event i occurred this cycle; may be high on consecutive cycles.
- cr_perf_event_select0  input  EVENT_IDX_WIDTH  event index counted by counter 0; level, may change on any cycle.
- cr_perf_event_select1  input  EVENT_IDX_WIDTH  event index counted by counter 1.
- perf_event_count0  output  64  registered count for counter 0.
- perf_event_count1  output  64  registered count for counter 1.

## Operation
- Per-counter state: sel_q (EVENT_IDX_WIDTH), count (64). Shared state: event_q (NUM_EVENTS).
- event_q <= perf_events on every non-reset edge. This is an input pipeline register for timing isolation from the pipeline stages.
- Counter update priority on each non-reset edge, evaluated independently per counter:
  1. If select ≠ sel_q: sel_q <= select, count <= 0. An event pending in event_q is not counted on this edge.
  2. Else if sel_q < NUM_EVENTS and event_q[sel_q] is high: count <= count + 1.
  3. Else: count holds.
- Out-of-range select (sel_q ≥ NUM_EVENTS, possible when NUM_EVENTS is not a power of two): the counter never increments. A change into or out of such a value still clears the counter.
- Arithmetic: unsigned 64-bit. 2^64−1 + 1 wraps to 0 with no flag and no stall.
- Both counters may select the same event. They then count identically, apart from differing clear times.
- perf_event_count0/1 are driven directly from the count registers, with no combinational path from any input.
- There is no write path into the counters. Software clears a counter only by changing its select, which means writing a different value and then the wanted value back.

## Timing
- Reset (reset low at an edge): count0/1 = 0, sel_q0/1 = 0, event_q = 0. Outputs read 0 from the first cycle after that edge. Reset asserted mid-count clears everything on that edge and overrides any select change or event pending on it.
- First edge after reset deasserts: event_q captures perf_events. If the select ≠ 0 on that edge, the counter clears (already 0) and adopts the new select.
- Event latency: a pulse on perf_events in cycle N is captured into event_q at the end of N and increments the count at the end of N+1. The new value is visible on the output in cycle N+2.
- Select change: a new select presented in cycle N is captured at the end of N, and the output reads 0 in cycle N+1.
  - The event_q contents at that edge (events from cycle N−1) are discarded.
  - Events in cycle N are then counted against the new select at the end of N+1.
- A select that is stable for K cycles with the selected event high every cycle gives a count that increases by exactly 1 per cycle after the 2-cycle latency.
- Simultaneous select change on one counter and an event on the other: the counters are fully independent.
- Throughput: one increment per counter per cycle, with no backpressure.

## Test plan
- Reset: hold reset low 3 cycles with perf_events = all ones and both selects = 3. Release → both outputs 0 during reset. The first release edge adopts sel 3 and clears; from there each counter increments by 1 per cycle, reading 1 two cycles after release.
- Latency and counting: with sel0 = 2 stable, pulse perf_events[2] once in cycle 10 → count0 = 0 through cycle 11 and 1 from cycle 12. A 5-cycle burst of the same event then gives count0 = 6.
- Select change clears: count0 = 40 with event 1 high continuously; change sel0 from 1 to 4 in cycle N while event 4 is high → count0 = 0 in N+1, 1 in N+2, 2 in N+3.
- Wrap: force count1 to 64'hFFFF_FFFF_FFFF_FFFE, then 3 selected events → outputs 64'hFFFF_FFFF_FFFF_FFFF, 0, 1. The carry across bit 31→32 is checked separately from 32'hFFFF_FFFF → 64'h1_0000_0000.
- Out-of-range select: NUM_EVENTS = 6, sel1 = 7, all events high for 20 cycles → count1 stays 0. Counter 0 (sel0 = 5) counts all 20 in parallel.
- Independence and reset mid-run: both counters on event 0, change sel1 only → count0 is unaffected and count1 clears. Assert reset once while count0 = 100 and an event is pending → both outputs 0 the next cycle.

Source files
------------

// File: rtl/perf_event_counters.sv
// Two free-running 64-bit event counters, each counting one software-selected event.
// Latency: event pulse to visible count is 2 cycles; select change to visible zero is 1 cycle.
// Backpressure: none; each counter accepts one increment per cycle.

// Single counter slice: tracks its own select and count against the shared event register.
module perf_event_counter_slice #(
   parameter int NUM_EVENTS      = 8,
   parameter int EVENT_IDX_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_EVENTS-1:0]      event_q,
   input  logic [EVENT_IDX_WIDTH-1:0] select,
   output logic [63:0]                count
);

   // Events padded to the full select range so any select value indexes safely;
   // padding bits are zero, so out-of-range selects can never see a hit.
   localparam int PAD_WIDTH = 2 ** EVENT_IDX_WIDTH;
   localparam logic [EVENT_IDX_WIDTH:0] NUM_EVENTS_L = NUM_EVENTS[EVENT_IDX_WIDTH:0];

   logic [EVENT_IDX_WIDTH-1:0] sel_q;
   logic [63:0]                count_q;
   logic [63:0]                count_nxt;
   logic [PAD_WIDTH-1:0]       event_pad;
   logic                       sel_change;
   logic                       sel_in_range;
   logic                       event_hit;

   // Zero-extend the registered events up to the select index space.
   always_comb begin
      event_pad                 = '0;
      event_pad[NUM_EVENTS-1:0] = event_q;
   end

   assign sel_change   = (select != sel_q);
   assign sel_in_range = ({1'b0, sel_q} < NUM_EVENTS_L);
   assign event_hit    = sel_in_range && event_pad[sel_q];

   // Next count: a select change clears and discards any pending event; otherwise count hits.
   always_comb begin
      count_nxt = count_q;
      if (sel_change) begin
         count_nxt = '0;
      end else if (event_hit) begin
         count_nxt = count_q + 64'd1;
      end
   end

   // State register; count is rewritten every edge so it always reflects count_nxt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q   <= '0;
         count_q <= '0;
      end else begin
         sel_q   <= select;
         count_q <= count_nxt;
      end
   end

   assign count = count_q;

endmodule

// Top: one shared input event register feeding two independent counter slices.
// Latency: 2 cycles from event pulse to count output, 1 cycle from select change to zero.
// Backpressure: none; outputs come straight from registers.
module perf_event_counters #(
   parameter int NUM_EVENTS      = 8,
   parameter int EVENT_IDX_WIDTH = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_EVENTS-1:0]      perf_events,
   input  logic [EVENT_IDX_WIDTH-1:0] cr_perf_event_select0,
   input  logic [EVENT_IDX_WIDTH-1:0] cr_perf_event_select1,
   output logic [63:0]                perf_event_count0,
   output logic [63:0]                perf_event_count1
);

   logic [NUM_EVENTS-1:0] event_q;

   // Input pipeline register isolating the counters from pipeline-stage timing.
   always_ff @(posedge clk) begin
      if (!reset) begin
         event_q <= '0;
      end else begin
         event_q <= perf_events;
      end
   end

   perf_event_counter_slice #(
      .NUM_EVENTS      (NUM_EVENTS),
      .EVENT_IDX_WIDTH (EVENT_IDX_WIDTH)
   ) u_cnt0 (
      .clk     (clk),
      .reset   (reset),
      .event_q (event_q),
      .select  (cr_perf_event_select0),
      .count   (perf_event_count0)
   );

   perf_event_counter_slice #(
      .NUM_EVENTS      (NUM_EVENTS),
      .EVENT_IDX_WIDTH (EVENT_IDX_WIDTH)
   ) u_cnt1 (
      .clk     (clk),
      .reset   (reset),
      .event_q (event_q),
      .select  (cr_perf_event_select1),
      .count   (perf_event_count1)
   );

endmodule

// File: tb/tb_perf_event_counters.sv
module tb_perf_event_counters;

   localparam int NE = 6;
   localparam int W  = 3;

   logic          clk;
   logic          reset;
   logic [NE-1:0] perf_events;
   logic [W-1:0]  sel0;
   logic [W-1:0]  sel1;
   logic [63:0]   count0;
   logic [63:0]   count1;

   int checks;
   int errors;

   perf_event_counters #(
      .NUM_EVENTS      (NE),
      .EVENT_IDX_WIDTH (W)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .perf_events           (perf_events),
      .cr_perf_event_select0 (sel0),
      .cr_perf_event_select1 (sel1),
      .perf_event_count0     (count0),
      .perf_event_count1     (count1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic          rst;
      logic [NE-1:0] ev;
      logic [W-1:0]  s0;
      logic [W-1:0]  s1;
      logic [63:0]   e0;
      logic [63:0]   e1;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait for the falling edge, compare both outputs, then drive inputs for the next rising edge.
   task automatic step(input string name, input logic [63:0] e0, input logic [63:0] e1,
                       input logic r, input logic [NE-1:0] ev, input logic [W-1:0] s0,
                       input logic [W-1:0] s1);
      @(negedge clk);
      chk({name, "/count0"}, count0, e0);
      chk({name, "/count1"}, count1, e1);
      reset       = r;
      perf_events = ev;
      sel0        = s0;
      sel1        = s1;
   endtask

   // Drive only, no comparison.
   task automatic drive(input logic [NE-1:0] ev, input logic [W-1:0] s0, input logic [W-1:0] s1);
      @(negedge clk);
      reset       = 1'b1;
      perf_events = ev;
      sel0        = s0;
      sel1        = s1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      perf_events = 6'h3F;
      sel0        = 3'd3;
      sel1        = 3'd3;

      // Each row: expected outputs seen at this step, then inputs for the next edge.
      tbl[0]  = '{1'b0, 6'h3F, 3'd3, 3'd3, 64'd0, 64'd0};
      tbl[1]  = '{1'b0, 6'h3F, 3'd3, 3'd3, 64'd0, 64'd0};
      tbl[2]  = '{1'b0, 6'h3F, 3'd3, 3'd3, 64'd0, 64'd0};
      tbl[3]  = '{1'b1, 6'h3F, 3'd3, 3'd3, 64'd0, 64'd0};
      tbl[4]  = '{1'b1, 6'h3F, 3'd3, 3'd3, 64'd0, 64'd0};
      tbl[5]  = '{1'b1, 6'h3F, 3'd3, 3'd3, 64'd1, 64'd1};
      tbl[6]  = '{1'b1, 6'h00, 3'd2, 3'd3, 64'd2, 64'd2};
      tbl[7]  = '{1'b1, 6'h00, 3'd2, 3'd3, 64'd0, 64'd3};
      tbl[8]  = '{1'b1, 6'h04, 3'd2, 3'd3, 64'd0, 64'd3};
      tbl[9]  = '{1'b1, 6'h00, 3'd2, 3'd3, 64'd0, 64'd3};
      tbl[10] = '{1'b1, 6'h04, 3'd2, 3'd3, 64'd1, 64'd3};
      tbl[11] = '{1'b1, 6'h04, 3'd2, 3'd3, 64'd1, 64'd3};
      tbl[12] = '{1'b1, 6'h04, 3'd2, 3'd3, 64'd2, 64'd3};
      tbl[13] = '{1'b1, 6'h04, 3'd2, 3'd3, 64'd3, 64'd3};
      tbl[14] = '{1'b1, 6'h04, 3'd2, 3'd3, 64'd4, 64'd3};
      tbl[15] = '{1'b1, 6'h00, 3'd2, 3'd3, 64'd5, 64'd3};
      tbl[16] = '{1'b1, 6'h00, 3'd2, 3'd3, 64'd6, 64'd3};
      tbl[17] = '{1'b1, 6'h00, 3'd2, 3'd3, 64'd6, 64'd3};

      for (int i = 0; i < 18; i++) begin
         step($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1,
              tbl[i].rst, tbl[i].ev, tbl[i].s0, tbl[i].s1);
      end

      // Select change clears: reach 40 on event 1, then move to event 4.
      for (int i = 0; i < 41; i++) drive(6'h12, 3'd1, 3'd3);
      step("selchg_pre", 64'd40, 64'd3, 1'b1, 6'h12, 3'd4, 3'd3);
      step("selchg_n1",  64'd0,  64'd3, 1'b1, 6'h12, 3'd4, 3'd3);
      step("selchg_n2",  64'd1,  64'd3, 1'b1, 6'h12, 3'd4, 3'd3);
      step("selchg_n3",  64'd2,  64'd3, 1'b1, 6'h00, 3'd4, 3'd3);

      // Out-of-range select on counter 1 while counter 0 counts all 20 events.
      for (int i = 0; i < 10; i++) drive(6'h3F, 3'd5, 3'd7);
      step("oor_mid", 64'd9, 64'd0, 1'b1, 6'h3F, 3'd5, 3'd7);
      for (int i = 0; i < 9; i++) drive(6'h3F, 3'd5, 3'd7);
      drive(6'h00, 3'd5, 3'd7);
      step("oor_end",  64'd20, 64'd0, 1'b1, 6'h00, 3'd5, 3'd7);
      step("oor_hold", 64'd20, 64'd0, 1'b1, 6'h00, 3'd0, 3'd2);

      // Wrap: preload counter 1 near the top, then three events on event 2.
      drive(6'h00, 3'd0, 3'd2);
      @(negedge clk);
      force dut.u_cnt1.count_q = 64'hFFFF_FFFF_FFFF_FFFE;
      @(negedge clk);
      release dut.u_cnt1.count_q;
      step("wrap_fe",   64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 6'h04, 3'd0, 3'd2);
      step("wrap_fe2",  64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 6'h04, 3'd0, 3'd2);
      step("wrap_ff",   64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'h04, 3'd0, 3'd2);
      step("wrap_zero", 64'd0, 64'd0,                   1'b1, 6'h00, 3'd0, 3'd2);
      step("wrap_one",  64'd0, 64'd1,                   1'b1, 6'h00, 3'd0, 3'd2);

      // Carry from bit 31 into bit 32.
      drive(6'h00, 3'd0, 3'd2);
      @(negedge clk);
      force dut.u_cnt1.count_q = 64'h0000_0000_FFFF_FFFF;
      @(negedge clk);
      release dut.u_cnt1.count_q;
      step("carry_pre",  64'd0, 64'h0000_0000_FFFF_FFFF, 1'b1, 6'h04, 3'd0, 3'd2);
      step("carry_pre2", 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b1, 6'h00, 3'd0, 3'd2);
      step("carry_post", 64'd0, 64'h0000_0001_0000_0000, 1'b1, 6'h00, 3'd0, 3'd0);

      // Both on event 0: run to 100, then reset with an event pending.
      for (int i = 0; i < 101; i++) drive(6'h01, 3'd0, 3'd0);
      step("pre_reset",  64'd100, 64'd100, 1'b0, 6'h01, 3'd0, 3'd0);
      step("mid_reset",  64'd0,   64'd0,   1'b1, 6'h01, 3'd0, 3'd0);
      step("post_rel0",  64'd0,   64'd0,   1'b1, 6'h01, 3'd0, 3'd0);
      step("post_rel1",  64'd1,   64'd1,   1'b1, 6'h01, 3'd0, 3'd0);
      // Independence: only counter 1 changes select.
      step("indep_pre",  64'd2,   64'd2,   1'b1, 6'h01, 3'd0, 3'd1);
      step("indep_clr",  64'd3,   64'd0,   1'b1, 6'h01, 3'd0, 3'd1);
      step("indep_run",  64'd4,   64'd0,   1'b1, 6'h00, 3'd0, 3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
